// File: rtl/h75_frame_writer.sv
// HUB75 frame-buffer write side: raster RGB888 stream into a double-buffered
// frame RAM, with upper/lower half-panel rows sharing one word.
module h75_frame_writer #(
  parameter int unsigned PANEL_ROWS = 64,
  parameter int unsigned X_W        = 9,
  parameter int unsigned Y_W        = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [X_W-1:0]       pixels_per_row,
  input  logic                 frame_sync,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_sof,
  input  logic [23:0]          s_data,
  output logic                 wr_en,
  output logic                 wr_bank,
  output logic [Y_W+X_W-1:0]   wr_addr,
  output logic [1:0]           wr_be,
  output logic [47:0]          wr_data,
  output logic                 rd_bank,
  output logic                 frame_done,
  output logic                 err_sof,
  output logic                 err_late
);

  localparam int unsigned ROW_W = Y_W + 1;
  localparam int unsigned HALF  = PANEL_ROWS / 2;

  typedef enum logic [1:0] {IDLE, WRITE, SWAP} state_t;

  state_t           state;
  logic             fs_q;
  logic [ROW_W-1:0] row;
  logic [X_W-1:0]   x;
  logic [X_W-1:0]   ppr;

  logic             fs_rise_c;
  logic             accept_c;
  logic             wr_go_c;
  logic [ROW_W-1:0] cur_row_c;
  logic [X_W-1:0]   cur_x_c;
  logic [X_W-1:0]   ppr_c;
  logic             x_last_c;
  logic             last_c;

  // A start-of-frame beat always writes at the origin with a freshly latched row length.
  always_comb begin
    fs_rise_c = frame_sync && !fs_q;
    accept_c  = s_valid && s_ready;
    wr_go_c   = accept_c && ((state == WRITE) || ((state == IDLE) && s_sof));
    cur_row_c = s_sof ? '0 : row;
    cur_x_c   = s_sof ? '0 : x;
    ppr_c     = ((state == IDLE) || s_sof) ? pixels_per_row : ppr;
    x_last_c  = (cur_x_c == (ppr_c - X_W'(1)));
    last_c    = x_last_c && (cur_row_c == ROW_W'(PANEL_ROWS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fs_q       <= 1'b0;
      row        <= '0;
      x          <= '0;
      ppr        <= '0;
      s_ready    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_be      <= 2'b00;
      wr_data    <= '0;
      rd_bank    <= 1'b0;
      wr_bank    <= 1'b1;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
      err_late   <= 1'b0;
    end else begin
      fs_q       <= frame_sync;
      wr_en      <= wr_go_c;
      frame_done <= wr_go_c && last_c;

      if (wr_go_c) begin
        wr_addr <= {cur_row_c[Y_W-1:0], cur_x_c};
        wr_be   <= (cur_row_c < ROW_W'(HALF)) ? 2'b01 : 2'b10;
        wr_data <= {s_data, s_data};
        ppr     <= ppr_c;
        x       <= x_last_c ? '0 : cur_x_c + X_W'(1);
        row     <= x_last_c ? cur_row_c + ROW_W'(1) : cur_row_c;
      end else begin
        wr_be   <= 2'b00;
      end

      case (state)
        IDLE, WRITE: begin
          s_ready <= 1'b1;
          if (fs_rise_c) err_late <= 1'b1;
          if ((state == WRITE) && accept_c && s_sof) err_sof <= 1'b1;
          if (wr_go_c) begin
            if (last_c) begin
              state   <= SWAP;
              s_ready <= 1'b0;
            end else begin
              state   <= WRITE;
            end
          end
        end
        SWAP: begin
          s_ready <= 1'b0;
          if (fs_rise_c) begin
            rd_bank <= ~rd_bank;
            wr_bank <= rd_bank;
            state   <= IDLE;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h75_frame_writer.sv
// Directed bench for h75_frame_writer: address table, full frames, bank swap and error corners.
module tb_h75_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  pixels_per_row;
  logic        frame_sync;
  logic        s_valid;
  logic        s_ready;
  logic        s_sof;
  logic [23:0] s_data;
  logic        wr_en;
  logic        wr_bank;
  logic [13:0] wr_addr;
  logic [1:0]  wr_be;
  logic [47:0] wr_data;
  logic        rd_bank;
  logic        frame_done;
  logic        err_sof;
  logic        err_late;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int          idx;
    logic [13:0] addr;
    logic [1:0]  be;
  } vec_t;

  vec_t        tv[6];
  logic [13:0] cap_addr[256];
  logic [1:0]  cap_be[256];

  always #5 clk = ~clk;

  h75_frame_writer dut (
    .clk(clk), .reset(reset), .pixels_per_row(pixels_per_row), .frame_sync(frame_sync),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_bank(rd_bank), .frame_done(frame_done), .err_sof(err_sof), .err_late(err_late)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, got, want);
  endtask

  function automatic logic [23:0] pix(input int i);
    return 24'(i * 131 + 7) ^ 24'hC33C99;
  endfunction

  // Expected {wr_en, frame_done, wr_addr, wr_be, wr_data} for beat idx of a frame.
  function automatic logic [65:0] exp_w(input int idx, input int ppr, input logic [23:0] d);
    int row;
    int xx;
    row = idx / ppr;
    xx  = idx % ppr;
    return {1'b1, (idx == 64 * ppr - 1), 5'(row), 9'(xx),
            (row < 32) ? 2'b01 : 2'b10, d, d};
  endfunction

  task automatic put(input string nm, input logic sof, input int idx, input int ppr);
    logic [23:0] d;
    d       = pix(idx + ppr * 1000);
    s_valid = 1'b1;
    s_sof   = sof;
    s_data  = d;
    step();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    chk(nm, {14'd0, wr_en, frame_done, wr_addr, wr_be, wr_data}, {14'd0, exp_w(idx, ppr, d)});
  endtask

  initial begin
    tv[0] = '{3,   14'h0003, 2'b01};
    tv[1] = '{4,   14'h0200, 2'b01};
    tv[2] = '{127, 14'h3E03, 2'b01};
    tv[3] = '{128, 14'h0000, 2'b10};
    tv[4] = '{129, 14'h0001, 2'b10};
    tv[5] = '{255, 14'h3E03, 2'b10};

    reset = 1'b1; pixels_per_row = 9'd4; frame_sync = 1'b0;
    s_valid = 1'b0; s_sof = 1'b0; s_data = 24'h0;
    repeat (3) step();
    chk("reset_state",
        {s_ready, wr_en, wr_addr, wr_be, wr_data, rd_bank, wr_bank, frame_done, err_sof, err_late},
        {1'b0, 1'b0, 14'h0, 2'b00, 48'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    step();
    chk("ready_after_reset", s_ready, 1);

    // T1: 64 rows of 4 pixels
    for (int i = 0; i < 256; i++) begin
      put("t1_write", i == 0, i, 4);
      cap_addr[i] = wr_addr;
      cap_be[i]   = wr_be;
    end
    for (int k = 0; k < 6; k++)
      chk($sformatf("t1_table_%0d", tv[k].idx),
          {cap_addr[tv[k].idx], cap_be[tv[k].idx]}, {tv[k].addr, tv[k].be});
    chk("t1_swap_not_ready", s_ready, 0);
    s_valid = 1'b1; s_sof = 1'b1; s_data = 24'h123456;
    step();
    s_valid = 1'b0; s_sof = 1'b0;
    chk("t1_no_write_in_swap", {wr_en, rd_bank, s_ready}, 3'b000);

    // T2: frame_sync rise commits the frame
    frame_sync = 1'b1;
    step();
    chk("t2_swap", {rd_bank, wr_bank, s_ready, err_late}, 4'b1010);
    step();
    chk("t2_level_no_reswap", {rd_bank, wr_bank}, 2'b10);
    frame_sync = 1'b0;
    step();

    // T3: mid-frame sof restarts the frame
    s_valid = 1'b1; s_sof = 1'b0; s_data = 24'hABCDEF;
    step();
    s_valid = 1'b0;
    chk("t3_idle_drop", wr_en, 0);
    for (int i = 0; i < 9; i++) put("t3_pre", i == 0, i, 4);
    chk("t3_err_sof_clear", err_sof, 0);
    put("t3_restart", 1'b1, 0, 4);
    chk("t3_err_sof_set", {err_sof, wr_addr, wr_be}, {1'b1, 14'h0, 2'b01});
    for (int i = 1; i < 256; i++) put("t3_frame", 1'b0, i, 4);
    frame_sync = 1'b1;
    step();
    chk("t3_swap", {rd_bank, wr_bank}, 2'b01);
    frame_sync = 1'b0;
    step();

    // T4: frame_sync during a frame is late, no swap
    for (int i = 0; i < 256; i++) begin
      if (i == 100) frame_sync = 1'b1;
      if (i == 101) frame_sync = 1'b0;
      put("t4_frame", i == 0, i, 4);
      if (i == 99)  chk("t4_late_clear", err_late, 0);
      if (i == 100) chk("t4_late_set", {err_late, rd_bank, wr_bank}, 3'b101);
    end
    step();
    chk("t4_held", {rd_bank, s_ready}, 2'b00);
    frame_sync = 1'b1;
    step();
    chk("t4_swap", {rd_bank, wr_bank}, 2'b10);
    frame_sync = 1'b0;
    step();

    // T5: ppr=64 with random valid gaps; last beat coincides with a frame_sync rise
    pixels_per_row = 9'd64;
    for (int i = 0; i < 4096; i++) begin
      while ($urandom_range(2) == 0) begin
        s_valid = 1'b0;
        s_data  = 24'($urandom);
        step();
        chk("t5_gap_no_write", wr_en, 0);
      end
      if (i == 4095) frame_sync = 1'b1;
      put("t5_write", i == 0, i, 64);
    end
    chk("t5_simul_no_swap", {rd_bank, s_ready, err_late}, 3'b101);
    frame_sync = 1'b0;
    step();
    chk("t5_still_held", rd_bank, 1);
    frame_sync = 1'b1;
    step();
    chk("t5_swap", {rd_bank, wr_bank}, 2'b01);
    frame_sync = 1'b0;
    step();

    // T6: reset mid-frame
    pixels_per_row = 9'd4;
    for (int i = 0; i < 50; i++) put("t6_pre", i == 0, i, 4);
    reset = 1'b1; s_valid = 1'b1; s_data = 24'h777777;
    step();
    chk("t6_reset", {wr_en, rd_bank, s_ready, err_sof, err_late, wr_bank}, 6'b000001);
    reset = 1'b0; s_valid = 1'b0;
    step();
    chk("t6_ready", s_ready, 1);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_sof = 1'b0; s_data = pix(i + 500);
      step();
      chk("t6_drop", wr_en, 0);
    end
    s_valid = 1'b0;
    put("t6_sof", 1'b1, 0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
